// File: rtl/step_clock_pkg.sv
// Shared types and constants for the step/free-run CPU clock generator.
package step_clock_pkg;

  localparam int unsigned CNT_W = 32;
  localparam logic [3:0] STEP_MODE = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_HOLD
  } step_state_t;

  function automatic logic [CNT_W-1:0] clock_period(input logic [CNT_W-1:0] hz,
                                                    input logic [3:0] sw);
    return hz >> sw;
  endfunction

endpackage

// File: rtl/step_clock_gen_debouncer.sv
// Button synchroniser and debounce counter; emits the clean level and a
// one-cycle press pulse on its rising edge. SYNC_STAGES must be at least 2.
module button_debouncer
  import step_clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic BUTTON,
  output logic BUTTON_CLEAN,
  output logic press_evt
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_q;
  logic                   clean_d;
  logic [CNT_W-1:0]       count;

  assign sync_q    = sync_r[SYNC_STAGES-1];
  assign press_evt = BUTTON_CLEAN & ~clean_d;

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      sync_r       <= '0;
      count        <= '0;
      BUTTON_CLEAN <= 1'b0;
      clean_d      <= 1'b0;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], BUTTON};
      clean_d <= BUTTON_CLEAN;
      // A bounce back to the current clean level restarts the stability window.
      if (sync_q == BUTTON_CLEAN) begin
        count <= '0;
      end else if (count == DB_LAST) begin
        BUTTON_CLEAN <= sync_q;
        count        <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/step_clock_gen.sv
// CPU clock source: free-running divider (CLOCK_HZ >> SWITCH) or, with
// SWITCH=0, one fixed-width SLOW_CLOCK pulse per debounced button press.
module step_clock_gen
  import step_clock_pkg::*;
#(
  parameter int unsigned CLOCK_HZ         = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES  = 1_000_000,
  parameter int unsigned STEP_HIGH_CYCLES = 25_000_000,
  parameter int unsigned SYNC_STAGES      = 2
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             BUTTON,
  input  logic [3:0]       SWITCH,
  output logic             SLOW_CLOCK,
  output logic [CNT_W-1:0] counter,
  output logic             STEP_BUSY,
  output logic             BUTTON_CLEAN
);

  localparam logic [CNT_W-1:0] HZ        = CNT_W'(CLOCK_HZ);
  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(STEP_HIGH_CYCLES - 1);

  logic             press_evt;
  logic [3:0]       mode_q;
  step_state_t      state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] par;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cnt_next;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_debounce (
    .CLOCK       (CLOCK),
    .RESET_N     (RESET_N),
    .BUTTON      (BUTTON),
    .BUTTON_CLEAN(BUTTON_CLEAN),
    .press_evt   (press_evt)
  );

  always_comb begin
    par      = clock_period(HZ, mode_q);
    half     = par >> 1;
    cnt_next = counter + CNT_W'(1);
    if (cnt_next >= par) cnt_next = '0;
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      mode_q     <= STEP_MODE;
      counter    <= '0;
      SLOW_CLOCK <= 1'b0;
      STEP_BUSY  <= 1'b0;
      state      <= ST_IDLE;
      timer      <= '0;
    end else if (SWITCH != mode_q) begin
      mode_q     <= SWITCH;
      counter    <= '0;
      SLOW_CLOCK <= 1'b0;
      STEP_BUSY  <= 1'b0;
      state      <= ST_IDLE;
      timer      <= '0;
    end else begin
      counter <= cnt_next;
      if (mode_q != STEP_MODE) begin
        // Derived from the next counter value so both change on the same edge.
        SLOW_CLOCK <= (cnt_next >= half);
      end else begin
        case (state)
          ST_IDLE: begin
            if (press_evt) begin
              state      <= ST_HIGH;
              SLOW_CLOCK <= 1'b1;
              STEP_BUSY  <= 1'b1;
              timer      <= '0;
            end
          end
          ST_HIGH: begin
            if (timer == HIGH_LAST) begin
              state      <= ST_HOLD;
              SLOW_CLOCK <= 1'b0;
            end else begin
              timer <= timer + CNT_W'(1);
            end
          end
          ST_HOLD: begin
            if (!BUTTON_CLEAN) begin
              state     <= ST_IDLE;
              STEP_BUSY <= 1'b0;
            end
          end
          default: begin
            state      <= ST_IDLE;
            SLOW_CLOCK <= 1'b0;
            STEP_BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_clock_gen.sv
// Bench for step_clock_gen: expected outputs per cycle are queued when the
// stimulus is driven and compared by a negedge monitor.
module tb_step_clock_gen;

  logic        CLOCK = 1'b0;
  logic        RESET_N;
  logic        BUTTON;
  logic [3:0]  SWITCH;
  logic        SLOW_CLOCK;
  logic [31:0] counter;
  logic        STEP_BUSY;
  logic        BUTTON_CLEAN;

  int unsigned cyc    = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    int unsigned at;
    int          slow;
    int          busy;
    int          clean;
    longint      cnt;
    logic [63:0] tag;
  } exp_t;

  typedef struct {
    logic [3:0]  sw;
    int unsigned par;
    int unsigned ncyc;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[4];

  step_clock_gen #(
    .CLOCK_HZ        (64),
    .DEBOUNCE_CYCLES (4),
    .STEP_HIGH_CYCLES(3),
    .SYNC_STAGES     (2)
  ) dut (
    .CLOCK       (CLOCK),
    .RESET_N     (RESET_N),
    .BUTTON      (BUTTON),
    .SWITCH      (SWITCH),
    .SLOW_CLOCK  (SLOW_CLOCK),
    .counter     (counter),
    .STEP_BUSY   (STEP_BUSY),
    .BUTTON_CLEAN(BUTTON_CLEAN)
  );

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;

  // -1 in any field means "not checked on this cycle".
  function automatic void push_exp(input int unsigned at, input int s, input int b,
                                   input int c, input longint n, input logic [63:0] tag);
    exp_t e;
    e.at = at; e.slow = s; e.busy = b; e.clean = c; e.cnt = n; e.tag = tag;
    sb.push_back(e);
  endfunction

  function automatic void check1(input logic [63:0] tag, input string what,
                                 input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %0s.%0s @cyc %0d: got %0h expected %0h", tag, what, cyc, act, exp);
    end
  endfunction

  always @(negedge CLOCK) begin
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        if (sb[i].slow  >= 0) check1(sb[i].tag, "slow",  {31'b0, SLOW_CLOCK},   32'(sb[i].slow));
        if (sb[i].busy  >= 0) check1(sb[i].tag, "busy",  {31'b0, STEP_BUSY},    32'(sb[i].busy));
        if (sb[i].clean >= 0) check1(sb[i].tag, "clean", {31'b0, BUTTON_CLEAN}, 32'(sb[i].clean));
        if (sb[i].cnt   >= 0) check1(sb[i].tag, "cnt",   counter,               32'(sb[i].cnt));
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        checks++;
        errors++;
        $display("FAIL %0s.missed: got none expected check at cyc %0d", sb[i].tag, sb[i].at);
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  initial begin
    int unsigned c, t0, r, p, m, p3;

    vecs[0] = '{sw: 4'd2, par: 16, ncyc: 34};
    vecs[1] = '{sw: 4'd3, par: 8,  ncyc: 18};
    vecs[2] = '{sw: 4'd5, par: 2,  ncyc: 6};
    vecs[3] = '{sw: 4'd0, par: 64, ncyc: 70};

    // Reset held for two edges with the button pressed.
    RESET_N = 1'b0; BUTTON = 1'b1; SWITCH = 4'd0;
    push_exp(1, 0, 0, 0, 0, "reset");
    push_exp(2, 0, 0, 0, 0, "reset");
    tick(); tick();
    RESET_N = 1'b1; BUTTON = 1'b0;

    // Divider table; SWITCH=0 still counts for the dimmer but SLOW_CLOCK stays low.
    foreach (vecs[v]) begin
      SWITCH = vecs[v].sw;
      c = cyc;
      for (int unsigned i = 0; i < vecs[v].ncyc; i++) begin
        int unsigned k;
        k = i % vecs[v].par;
        push_exp(c + 1 + i, (vecs[v].sw == 4'd0) ? 0 : int'(k >= vecs[v].par / 2),
                 0, 0, k, "divider");
      end
      repeat (vecs[v].ncyc) tick();
    end

    // Bounce every 2 cycles, then hold.
    c = cyc;
    for (int unsigned e = c + 1; e <= c + 17; e++) push_exp(e, 0, 0, 0, -1, "bounce");
    for (int k = 0; k < 12; k++) begin
      BUTTON = ((k / 2) % 2 == 0);
      tick();
    end
    t0 = cyc;
    BUTTON = 1'b1;
    push_exp(t0 + 6, 0, 0, 1, -1, "press");
    for (int unsigned e = t0 + 7; e <= t0 + 9; e++) push_exp(e, 1, 1, 1, -1, "pulse");
    push_exp(t0 + 10, 0, 1, 1, -1, "pulse");

    // Long hold: a single pulse, busy until one cycle after the clean level falls.
    for (int unsigned e = t0 + 11; e <= t0 + 100; e++) push_exp(e, 0, 1, 1, -1, "hold");
    repeat (t0 + 100 - cyc) tick();
    r = cyc;
    BUTTON = 1'b0;
    for (int unsigned e = r + 1; e <= r + 5; e++) push_exp(e, 0, 1, 1, -1, "release");
    push_exp(r + 6, 0, 1, 0, -1, "release");
    for (int unsigned e = r + 7; e <= r + 9; e++) push_exp(e, 0, 0, 0, -1, "release");
    repeat (10) tick();
    p = cyc;
    BUTTON = 1'b1;
    for (int unsigned e = p + 1; e <= p + 5; e++) push_exp(e, 0, 0, 0, -1, "repress");
    push_exp(p + 6, 0, 0, 1, -1, "repress");
    for (int unsigned e = p + 7; e <= p + 9; e++) push_exp(e, 1, 1, 1, -1, "repress");
    for (int unsigned e = p + 10; e <= p + 12; e++) push_exp(e, 0, 1, 1, -1, "repress");
    repeat (12) tick();

    // Mode change while SLOW_CLOCK is high in a step pulse.
    BUTTON = 1'b0;
    r = cyc;
    push_exp(r + 6, 0, 1, 0, -1, "rel2");
    push_exp(r + 7, 0, 0, 0, -1, "rel2");
    repeat (8) tick();
    p = cyc;
    BUTTON = 1'b1;
    push_exp(p + 6, 0, 0, 1, -1, "press3");
    push_exp(p + 7, 1, 1, 1, -1, "press3");
    repeat (7) tick();
    SWITCH = 4'd3;
    m = cyc;
    for (int unsigned i = 0; i < 18; i++)
      push_exp(m + 1 + i, int'((i % 8) >= 4), 0, 1, i % 8, "modechg");
    repeat (18) tick();

    // Reset during a step pulse, button held throughout.
    SWITCH = 4'd0;
    BUTTON = 1'b0;
    r = cyc;
    push_exp(r + 1, 0, 0, 1, 0, "tostep");
    push_exp(r + 6, 0, 0, 0, -1, "tostep");
    repeat (8) tick();
    p3 = cyc;
    BUTTON = 1'b1;
    push_exp(p3 + 7, 1, 1, 1, -1, "press4");
    push_exp(p3 + 8, 1, 1, 1, -1, "press4");
    repeat (8) tick();
    RESET_N = 1'b0;
    push_exp(p3 + 9, 0, 0, 0, 0, "rstmid");
    tick();
    RESET_N = 1'b1;
    for (int unsigned e = p3 + 10; e <= p3 + 14; e++) push_exp(e, 0, 0, 0, e - (p3 + 9), "rstpost");
    push_exp(p3 + 15, 0, 0, 1, 6, "rstpost");
    for (int unsigned e = p3 + 16; e <= p3 + 18; e++) push_exp(e, 1, 1, 1, e - (p3 + 9), "rstpulse");
    for (int unsigned e = p3 + 19; e <= p3 + 40; e++) push_exp(e, 0, 1, 1, e - (p3 + 9), "onepulse");
    repeat (31) tick();

    repeat (2) tick();
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %0s.unchecked: got none expected check at cyc %0d", sb[0].tag, sb[0].at);
      void'(sb.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
